ps2_key_event_ctrl: RTL and testbench

PS2_KEY_EVENT_CTRL -- requirements
Module: ps2_key_event_ctrl

---
 rtl/ps2_pkg.sv | 42 ++++
 rtl/ps2_evt_fifo.sv | 67 ++++++
 rtl/ps2_key_event_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ps2_key_event_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 key event controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] C_CODE_E0 = 8'hE0;
    localparam logic [7:0] C_CODE_F0 = 8'hF0;

    // Keyboard command responses that never represent a key.
    localparam logic [7:0] C_RESP_ACK    = 8'hFA;
    localparam logic [7:0] C_RESP_BAT_OK = 8'hAA;
    localparam logic [7:0] C_RESP_ECHO   = 8'hEE;
    localparam logic [7:0] C_RESP_RESEND = 8'hFE;
    localparam logic [7:0] C_RESP_ERR_FF = 8'hFF;
    localparam logic [7:0] C_RESP_ERR_00 = 8'h00;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       make;
    } evt_t;

    localparam int C_EVT_W = $bits(evt_t);

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == C_RESP_ACK)    || (b == C_RESP_BAT_OK) ||
               (b == C_RESP_ECHO)   || (b == C_RESP_RESEND) ||
               (b == C_RESP_ERR_FF) || (b == C_RESP_ERR_00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_evt_fifo
// Description : First-word-fall-through event queue with valid/ready pop.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_full,
    output logic             o_drop,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    localparam int            C_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [C_AW:0] C_DEPTH = (C_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW-1:0]  r_rd_ptr;
    logic [C_AW:0]    r_count;
    logic             w_pop;
    logic             w_wr;

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == C_DEPTH);
    assign w_pop   = o_valid && i_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign w_wr    = i_push && (!o_full || w_pop);
    assign o_drop  = i_push && !w_wr;
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_event_ctrl
// Description : Decodes PS/2 set-2 scan bytes into queued make/release events.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       rx_err,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_make,
    output logic       key_held,
    output logic [7:0] held_code,
    output logic [7:0] press_count,
    output logic       overflow,
    input  logic       clr_overflow
);

    localparam int              C_TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_TW-1:0] C_TIMEOUT_LAST = C_TW'(TIMEOUT_CYCLES - 1);

    state_t          r_state;
    logic [C_TW-1:0] r_timer;
    logic            r_key_held;
    logic [7:0]      r_held_code;
    logic            r_held_ext;
    logic [7:0]      r_press_count;
    logic            r_overflow;

    state_t          w_next_state;
    logic            w_is_event;
    logic            w_make;
    logic            w_ext;
    logic            w_repeat;
    logic            w_push;
    logic            w_drop;
    logic            w_full;
    evt_t            w_new_evt;
    evt_t            w_head;
    logic [C_EVT_W-1:0] w_head_bits;

    always_comb begin
        w_next_state = r_state;
        w_is_event   = 1'b0;
        w_make       = 1'b0;
        w_ext        = 1'b0;
        if (rx_err) begin
            w_next_state = ST_IDLE;
        end else if (rx_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_byte == C_CODE_E0) begin
                        w_next_state = ST_EXT;
                    end else if (rx_byte == C_CODE_F0) begin
                        w_next_state = ST_BRK;
                    end else if (!is_ignored(rx_byte)) begin
                        w_is_event = 1'b1;
                        w_make     = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (rx_byte == C_CODE_F0) begin
                        w_next_state = ST_EXT_BRK;
                    end else if (rx_byte != C_CODE_E0) begin
                        w_is_event   = 1'b1;
                        w_make       = 1'b1;
                        w_ext        = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
                default: begin
                    // A prefix after F0 means the stream lost sync; drop it.
                    w_next_state = ST_IDLE;
                    if ((rx_byte != C_CODE_E0) && (rx_byte != C_CODE_F0)) begin
                        w_is_event = 1'b1;
                        w_ext      = (r_state == ST_EXT_BRK);
                    end
                end
            endcase
        end else if ((r_state != ST_IDLE) && (r_timer == C_TIMEOUT_LAST)) begin
            w_next_state = ST_IDLE;
        end
    end

    // Auto-repeat of the key already held produces neither event nor count.
    assign w_repeat  = w_is_event && w_make && r_key_held &&
                       (rx_byte == r_held_code) && (w_ext == r_held_ext);
    assign w_push    = w_is_event && !w_repeat;
    assign w_new_evt = '{code: rx_byte, ext: w_ext, make: w_make};

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (C_EVT_W)
    ) u_evt_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_new_evt),
        .o_full      (w_full),
        .o_drop      (w_drop),
        .o_valid     (evt_valid),
        .i_ready     (evt_ready),
        .o_data      (w_head_bits)
    );

    assign w_head = evt_t'(w_head_bits);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_key_held    <= 1'b0;
            r_held_code   <= '0;
            r_held_ext    <= 1'b0;
            r_press_count <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (rx_valid || rx_err || (w_next_state == ST_IDLE)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_push && w_make) begin
                r_key_held    <= 1'b1;
                r_held_code   <= rx_byte;
                r_held_ext    <= w_ext;
                r_press_count <= r_press_count + 1'b1;
            end else if (w_push && (rx_byte == r_held_code) && (w_ext == r_held_ext)) begin
                r_key_held <= 1'b0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign evt_code    = w_head.code;
    assign evt_ext     = w_head.ext;
    assign evt_make    = w_head.make;
    assign key_held    = r_key_held;
    assign held_code   = r_held_code;
    assign press_count = r_press_count;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_event_ctrl
// Description : Directed self-checking bench for ps2_key_event_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_event_ctrl;

    localparam int C_DEPTH = 8;
    localparam int C_TO    = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_err = 1'b0;
    logic       evt_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_make;
    logic       key_held;
    logic [7:0] held_code;
    logic [7:0] press_count;
    logic       overflow;

    int n_pass   = 0;
    int n_fail   = 0;
    int n_checks = 0;

    logic [7:0] codes [9];

    always #5 clk = ~clk;

    ps2_key_event_ctrl #(
        .FIFO_DEPTH     (C_DEPTH),
        .TIMEOUT_CYCLES (C_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .rx_err       (rx_err),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_ext      (evt_ext),
        .evt_make     (evt_make),
        .key_held     (key_held),
        .held_code    (held_code),
        .press_count  (press_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Head layout checked as {valid, code, ext, make}.
    task automatic pop_expect(input string tag, input logic [7:0] code,
                              input logic ext, input logic make);
        chk(tag, {evt_valid, evt_code, evt_ext, evt_make}, {1'b1, code, ext, make});
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    initial begin
        codes = '{8'h15, 8'h16, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43};
        repeat (3) @(negedge clk);
        chk("reset_head",   {evt_valid, evt_code, evt_ext, evt_make}, 11'd0);
        chk("reset_held",   {key_held, held_code}, 9'd0);
        chk("reset_count",  press_count, 8'd0);
        chk("reset_ovf",    overflow, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_head", {evt_valid, evt_code, evt_ext, evt_make}, 11'd0);

        // Plain make/release; state visible one cycle after the byte.
        send_byte(8'h1C);
        chk("make_latency", {evt_valid, key_held, held_code, press_count}, {1'b1, 1'b1, 8'h1C, 8'd1});
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("release_held", key_held, 1'b0);
        pop_expect("s1_make", 8'h1C, 1'b0, 1'b1);
        pop_expect("s1_rel",  8'h1C, 1'b0, 1'b0);
        chk("s1_empty", {evt_valid, press_count}, {1'b0, 8'd1});

        // Typematic repeats are suppressed.
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        pop_expect("s2_make", 8'h1C, 1'b0, 1'b1);
        pop_expect("s2_rel",  8'h1C, 1'b0, 1'b0);
        chk("s2_empty", {evt_valid, press_count, key_held}, {1'b0, 8'd2, 1'b0});

        // Extended key with interleaved keyboard responses.
        send_byte(8'hAA);
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hFA);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        send_byte(8'hEE);
        pop_expect("s3_make", 8'h75, 1'b1, 1'b1);
        pop_expect("s3_rel",  8'h75, 1'b1, 1'b0);
        chk("s3_empty", {evt_valid, press_count, key_held}, {1'b0, 8'd3, 1'b0});

        // rx_err after E0 drops the prefix.
        send_byte(8'hE0);
        rx_err = 1'b1;
        @(negedge clk);
        rx_err = 1'b0;
        send_byte(8'h1C);
        pop_expect("err_make", 8'h1C, 1'b0, 1'b1);
        chk("err_count", press_count, 8'd4);
        send_byte(8'hF0);
        send_byte(8'h1C);
        pop_expect("err_rel", 8'h1C, 1'b0, 1'b0);

        // One cycle short of the timeout keeps the prefix.
        send_byte(8'hE0);
        repeat (C_TO - 1) @(negedge clk);
        send_byte(8'h7D);
        pop_expect("to_edge_make", 8'h7D, 1'b1, 1'b1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h7D);
        pop_expect("to_edge_rel", 8'h7D, 1'b1, 1'b0);

        // Full timeout returns to IDLE.
        send_byte(8'hE0);
        repeat (C_TO) @(negedge clk);
        send_byte(8'h1C);
        pop_expect("to_make", 8'h1C, 1'b0, 1'b1);
        chk("to_count", {press_count, key_held, held_code}, {8'd6, 1'b1, 8'h1C});

        // rx_err overrides a simultaneous rx_valid.
        send_byte(8'hF0);
        rx_byte  = 8'h1C;
        rx_valid = 1'b1;
        rx_err   = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        chk("err_override", {evt_valid, key_held}, {1'b0, 1'b1});
        send_byte(8'h1C);
        chk("repeat_after_err", {evt_valid, press_count}, {1'b0, 8'd6});
        send_byte(8'hF0);
        send_byte(8'h1C);
        pop_expect("s5_rel", 8'h1C, 1'b0, 1'b0);
        chk("s5_released", key_held, 1'b0);

        // Overflow: nine distinct makes with no consumer.
        for (int i = 0; i < 8; i++) begin
            send_byte(codes[i]);
        end
        chk("full_no_ovf", {evt_valid, overflow}, {1'b1, 1'b0});
        rx_byte      = codes[8];
        rx_valid     = 1'b1;
        clr_overflow = 1'b1;
        @(negedge clk);
        rx_valid     = 1'b0;
        clr_overflow = 1'b0;
        chk("ovf_set_wins", overflow, 1'b1);
        chk("ovf_state", {press_count, held_code}, {8'd15, 8'h43});
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("ovf_clear", overflow, 1'b0);

        // Push and pop together on a full queue.
        rx_byte   = 8'h4B;
        rx_valid  = 1'b1;
        evt_ready = 1'b1;
        @(negedge clk);
        rx_valid  = 1'b0;
        evt_ready = 1'b0;
        chk("full_pushpop", {overflow, press_count}, {1'b0, 8'd16});
        for (int i = 1; i < 8; i++) begin
            pop_expect("fifo_order", codes[i], 1'b0, 1'b1);
        end
        pop_expect("fifo_last", 8'h4B, 1'b0, 1'b1);
        chk("fifo_drained", evt_valid, 1'b0);

        // Reset in the middle of a break sequence with a queued event.
        send_byte(8'h1C);
        send_byte(8'hF0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_head", {evt_valid, evt_code, evt_ext, evt_make}, 11'd0);
        chk("mid_rst_state", {key_held, held_code, press_count, overflow}, 18'd0);
        send_byte(8'h1C);
        pop_expect("after_rst_make", 8'h1C, 1'b0, 1'b1);
        chk("after_rst_count", press_count, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
